fifo_ptr_ctrl: RTL and testbench

- Control unit for the FIFO2 storage path.
- Owns the write and read pointer counters, which are ripple half-adder style enable counters with carry-out.
- Accepts write and read requests, gates them against full and empty, and drives the memory write strobe and read/write addresses.
- Produces registered status flags (empty, full, almost_full, level) and sticky overflow/underflow error flags.
- Sits between requesters and the FIFO register file.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/ptr_counter.sv | 47 ++++
 rtl/fifo_ptr_ctrl.sv | 126 ++++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the FIFO2 pointer control path
//
// Holds the default pointer width, the depth and level-width it implies,
// and a helper that derives the depth for any pointer width.
package fifo_pkg;

    localparam int FIFO_ADDR_W = 2;
    localparam int FIFO_DEPTH  = 1 << FIFO_ADDR_W;
    localparam int FIFO_LVL_W  = FIFO_ADDR_W + 1;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage : fifo_pkg

// File: rtl/ptr_counter.sv
// rtl/ptr_counter.sv - ripple half-adder enable counter with carry-out
//
// Ports:
//   clock  - rising-edge clock
//   clear  - asynchronous active-low reset, returns q to 0
//   en     - count enable, advances q by one on the clock edge
//   q      - current count (ADDR_W bits)
//   carry  - combinational carry-out, high when en is set and q is all ones
module ptr_counter
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              en,
    output logic [ADDR_W-1:0] q,
    output logic              carry
);

    logic [ADDR_W-1:0] q_q;
    logic [ADDR_W-1:0] q_d;
    logic [ADDR_W:0]   c;

    // Chain of half adders: the enable is the carry into bit 0.
    always_comb begin
        c    = '0;
        q_d  = q_q;
        c[0] = en;
        for (int i = 0; i < ADDR_W; i++) begin
            q_d[i]   = q_q[i] ^ c[i];
            c[i + 1] = q_q[i] & c[i];
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = c[ADDR_W];

endmodule : ptr_counter

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - FIFO2 pointer, level, status flag and error control
//
// Ports:
//   clock, clear      - clock and asynchronous active-low reset
//   wr_req, rd_req    - write / read requests for this cycle
//   mem_we            - memory write strobe (write accepted this cycle)
//   waddr, raddr      - current write / read pointers
//   rd_ack            - read accepted this cycle
//   empty, full       - registered occupancy status
//   almost_full       - registered, level >= AF_LEVEL
//   level             - registered occupancy 0..DEPTH
//   ovf, udf          - sticky overflow / underflow errors
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W   = FIFO_ADDR_W,
    parameter int AF_LEVEL = 3
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              wr_req,
    input  logic              rd_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    output logic              rd_ack,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic              ovf,
    output logic              udf
);

    localparam int LVL_W = ADDR_W + 1;
    localparam int DEPTH = depth_of(ADDR_W);
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AF_L    = LVL_W'(AF_LEVEL);

    logic             wa;
    logic             ra;
    logic             w_carry;
    logic             r_carry;

    logic             wrap_w_q, wrap_w_d;
    logic             wrap_r_q, wrap_r_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic             empty_q,  empty_d;
    logic             full_q,   full_d;
    logic             af_q,     af_d;
    logic             ovf_q,    ovf_d;
    logic             udf_q,    udf_d;

    // Accept decisions use only the registered flags, so a full FIFO never
    // passes a write through and an empty FIFO never bypasses a read.
    assign wa = wr_req & ~full_q;
    assign ra = rd_req & ~empty_q;

    ptr_counter #(.ADDR_W(ADDR_W)) u_wptr (
        .clock (clock),
        .clear (clear),
        .en    (wa),
        .q     (waddr),
        .carry (w_carry)
    );

    ptr_counter #(.ADDR_W(ADDR_W)) u_rptr (
        .clock (clock),
        .clear (clear),
        .en    (ra),
        .q     (raddr),
        .carry (r_carry)
    );

    always_comb begin
        wrap_w_d = wrap_w_q ^ w_carry;
        wrap_r_d = wrap_r_q ^ r_carry;

        // Accept rules keep level inside 0..DEPTH, so no saturation here.
        level_d = level_q;
        case ({wa, ra})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        empty_d = (level_d == '0);
        full_d  = (level_d == DEPTH_L);
        af_d    = (level_d >= AF_L);

        ovf_d = ovf_q | (wr_req & full_q);
        udf_d = udf_q | (rd_req & empty_q);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wrap_w_q <= 1'b0;
            wrap_r_q <= 1'b0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wrap_w_q <= wrap_w_d;
            wrap_r_q <= wrap_r_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign mem_we      = wa;
    assign rd_ack      = ra;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign level       = level_q;
    assign ovf         = ovf_q;
    assign udf         = udf_q;

endmodule : fifo_ptr_ctrl

// File: tb/tb_fifo_ptr_ctrl.sv
// tb/tb_fifo_ptr_ctrl.sv - self-checking bench for fifo_ptr_ctrl against a counting reference model
module tb_fifo_ptr_ctrl;

    localparam int ADDR_W   = 2;
    localparam int AF_LEVEL = 3;
    localparam int DEPTH    = 1 << ADDR_W;

    logic              clock;
    logic              clear;
    logic              wr_req;
    logic              rd_req;
    logic              mem_we;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic              rd_ack;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   level;
    logic              ovf;
    logic              udf;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: total accepted writes and reads since reset.
    int m_wcnt;
    int m_rcnt;
    bit m_ovf;
    bit m_udf;

    fifo_ptr_ctrl #(.ADDR_W(ADDR_W), .AF_LEVEL(AF_LEVEL)) dut (
        .clock       (clock),
        .clear       (clear),
        .wr_req      (wr_req),
        .rd_req      (rd_req),
        .mem_we      (mem_we),
        .waddr       (waddr),
        .raddr       (raddr),
        .rd_ack      (rd_ack),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .level       (level),
        .ovf         (ovf),
        .udf         (udf)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_level();
        return m_wcnt - m_rcnt;
    endfunction

    task automatic model_reset();
        m_wcnt = 0;
        m_rcnt = 0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic check_all();
        int  lvl;
        bit  m_full;
        bit  m_empty;
        lvl     = m_level();
        m_full  = (lvl == DEPTH);
        m_empty = (lvl == 0);
        chk("mem_we", int'(mem_we), int'(wr_req && !m_full));
        chk("rd_ack", int'(rd_ack), int'(rd_req && !m_empty));
        chk("waddr", int'(waddr), m_wcnt % DEPTH);
        chk("raddr", int'(raddr), m_rcnt % DEPTH);
        chk("level", int'(level), lvl);
        chk("empty", int'(empty), int'(m_empty));
        chk("full", int'(full), int'(m_full));
        chk("almost_full", int'(almost_full), int'(lvl >= AF_LEVEL));
        chk("ovf", int'(ovf), int'(m_ovf));
        chk("udf", int'(udf), int'(m_udf));
    endtask

    // Called just after a falling edge: drive, check, advance model, clock.
    task automatic step(input bit w, input bit r);
        int lvl;
        bit acc_w;
        bit acc_r;
        wr_req = w;
        rd_req = r;
        #1;
        check_all();
        lvl   = m_level();
        acc_w = w && (lvl != DEPTH);
        acc_r = r && (lvl != 0);
        if (w && lvl == DEPTH) m_ovf = 1'b1;
        if (r && lvl == 0)     m_udf = 1'b1;
        if (acc_w) m_wcnt++;
        if (acc_r) m_rcnt++;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_af"}, int'(almost_full), 0);
        chk({tag, "_level"}, int'(level), 0);
        chk({tag, "_waddr"}, int'(waddr), 0);
        chk({tag, "_raddr"}, int'(raddr), 0);
        chk({tag, "_ovf"}, int'(ovf), 0);
        chk({tag, "_udf"}, int'(udf), 0);
    endtask

    // Asynchronous clear between clock edges, with random requests present.
    task automatic clear_pulse(input string tag);
        wr_req = 1'($urandom);
        rd_req = 1'($urandom);
        #2;
        clear = 1'b0;
        #1;
        check_reset_values(tag);
        model_reset();
        @(negedge clock);
        clear  = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    initial begin
        clear  = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        model_reset();

        // Reset without any clock edge in between.
        #1;
        wr_req = 1'($urandom);
        rd_req = 1'($urandom);
        clear  = 1'b0;
        #1;
        check_reset_values("rst");
        @(negedge clock);
        clear  = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;

        // Fill to full; waddr wraps back to 0.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0);
        chk("fill_level", int'(level), 4);
        chk("fill_full", int'(full), 1);
        chk("fill_waddr_wrap", int'(waddr), 0);

        // Overflow attempt, then idle; ovf must stay set.
        step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        chk("ovf_sticky", int'(ovf), 1);

        // Drain, then underflow attempt.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1);
        chk("drain_empty", int'(empty), 1);
        step(1'b0, 1'b1);
        chk("udf_set", int'(udf), 1);

        // Simultaneous requests at level 2.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
        chk("simul_level", int'(level), 2);

        // Full with both requests: only the read goes.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("full_both_level", int'(level), 3);

        // Empty with both requests: only the write goes.
        clear_pulse("clr1");
        step(1'b1, 1'b1);
        chk("empty_both_level", int'(level), 1);
        chk("empty_both_udf", int'(udf), 1);

        // Mid-fill clear.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        clear_pulse("clr2");
        step(1'b0, 1'b0);

        // Random traffic with occasional clears.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                clear_pulse("clr_rnd");
            end else begin
                step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_fifo_ptr_ctrl
